// File: rtl/mesh_to_spm_arb.sv
// rtl/mesh_to_spm_arb.sv - merges PE egress FIFOs into one tagged, registered SPM-facing FIFO
// Fixed-select or burst-limited round-robin arbitration feeding a small circular output buffer.
module mesh_to_spm_arb #(
  parameter int FIFO_WIDTH    = 36,
  parameter int NUM_EGRESS_PE = 4,
  parameter int OUT_DEPTH     = 2,
  parameter int BURST_LEN     = 4,
  localparam int IW = $clog2(NUM_EGRESS_PE),
  localparam int CW = $clog2(OUT_DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rr_mode_i,
  input  logic [IW-1:0]            sel_i,
  output logic                     empty_o,
  output logic [FIFO_WIDTH-1:0]    rdata_o,
  output logic [IW-1:0]            src_id_o,
  output logic [CW-1:0]            count_o,
  input  logic                     dequeue_i,
  input  logic [NUM_EGRESS_PE-1:0] egress_empty_i,
  input  logic [FIFO_WIDTH-1:0]    egress_rdata_i [NUM_EGRESS_PE],
  output logic [NUM_EGRESS_PE-1:0] egress_dequeue_o
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int EW = IW + FIFO_WIDTH;

  logic [EW-1:0] mem_q [OUT_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] bcnt_q, bcnt_d, bcnt_nxt;
  logic          pop, space, gnt_vld, push;
  logic [IW-1:0] gnt_idx, cand;

  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign pop      = dequeue_i && !empty_o;
  assign space    = (count_q < CW'(OUT_DEPTH)) || pop;
  assign push     = space && gnt_vld;
  assign rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q][FIFO_WIDTH-1:0];
  assign src_id_o = empty_o ? '0 : mem_q[rd_ptr_q][EW-1:FIFO_WIDTH];

  // Search runs from the farthest offset down so the nearest non-empty PE to ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (rr_mode_i) begin
      for (int k = NUM_EGRESS_PE - 1; k >= 0; k--) begin
        cand = IW'((int'(ptr_q) + k) % NUM_EGRESS_PE);
        if (!egress_empty_i[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end else if (!egress_empty_i[sel_i]) begin
      gnt_vld = 1'b1;
      gnt_idx = sel_i;
    end
  end

  // Gated by rst_ni so an in-flight pop drops the instant reset asserts.
  always_comb begin
    egress_dequeue_o = '0;
    if (rst_ni && push) begin
      egress_dequeue_o[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    bcnt_d   = bcnt_q;
    bcnt_nxt = (gnt_idx == ptr_q) ? bcnt_q + 1'b1 : BW'(1);
    if (!rr_mode_i) begin
      ptr_d  = sel_i;
      bcnt_d = '0;
    end else if (push) begin
      if (bcnt_nxt == BW'(BURST_LEN)) begin
        ptr_d  = (gnt_idx == IW'(NUM_EGRESS_PE - 1)) ? '0 : gnt_idx + 1'b1;
        bcnt_d = '0;
      end else begin
        ptr_d  = gnt_idx;
        bcnt_d = bcnt_nxt;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ptr_q    <= '0;
      bcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      bcnt_q   <= bcnt_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {gnt_idx, egress_rdata_i[gnt_idx]};
    end
  end

endmodule

// File: tb/tb_mesh_to_spm_arb.sv
// tb/tb_mesh_to_spm_arb.sv - randomized and directed checks of mesh_to_spm_arb against a queue-based model
module tb_mesh_to_spm_arb;

  localparam int W = 36;
  localparam int N = 4;
  localparam int D = 2;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic rr_mode_i = 1'b0;
  logic dequeue_i = 1'b0;
  logic [1:0] sel_i = '0;
  logic [N-1:0] eemp [2];
  logic [W-1:0] erd0 [N];
  logic [W-1:0] erd1 [N];
  logic         emp_o [2];
  logic [W-1:0] rd_o [2];
  logic [1:0]   src_o [2];
  logic [1:0]   cnt_o [2];
  logic [N-1:0] edq_o [2];

  logic [W-1:0] fq [2*N][$];
  logic [W+1:0] obq [2][$];
  logic [W+1:0] plog [2][$];
  int mptr [2];
  int mbcnt [2];
  int bl [2] = '{4, 2};
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  mesh_to_spm_arb #(.FIFO_WIDTH(W), .NUM_EGRESS_PE(N), .OUT_DEPTH(D), .BURST_LEN(4)) dut_bl4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .rr_mode_i(rr_mode_i), .sel_i(sel_i),
    .empty_o(emp_o[0]), .rdata_o(rd_o[0]), .src_id_o(src_o[0]), .count_o(cnt_o[0]),
    .dequeue_i(dequeue_i), .egress_empty_i(eemp[0]), .egress_rdata_i(erd0),
    .egress_dequeue_o(edq_o[0])
  );

  mesh_to_spm_arb #(.FIFO_WIDTH(W), .NUM_EGRESS_PE(N), .OUT_DEPTH(D), .BURST_LEN(2)) dut_bl2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .rr_mode_i(rr_mode_i), .sel_i(sel_i),
    .empty_o(emp_o[1]), .rdata_o(rd_o[1]), .src_id_o(src_o[1]), .count_o(cnt_o[1]),
    .dequeue_i(dequeue_i), .egress_empty_i(eemp[1]), .egress_rdata_i(erd1),
    .egress_dequeue_o(edq_o[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_egress();
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < N; k++) begin
        eemp[u][k] = (fq[u*N+k].size() == 0);
      end
    end
    for (int k = 0; k < N; k++) begin
      erd0[k] = (fq[k].size() > 0) ? fq[k][0] : '0;
      erd1[k] = (fq[N+k].size() > 0) ? fq[N+k][0] : '0;
    end
  endtask

  task automatic load(input int k, input int nwords, input logic [W-1:0] base);
    for (int i = 0; i < nwords; i++) begin
      fq[k].push_back(base + W'(i));
      fq[N+k].push_back(base + W'(i));
    end
  endtask

  function automatic int model_grant(input int u);
    int  qs;
    bit  pv;
    int  k;
    qs = obq[u].size();
    pv = dequeue_i && (qs > 0);
    if (!(qs < D || pv)) return -1;
    if (!rr_mode_i) return (fq[u*N+int'(sel_i)].size() > 0) ? int'(sel_i) : -1;
    for (int o = 0; o < N; o++) begin
      k = (mptr[u] + o) % N;
      if (fq[u*N+k].size() > 0) return k;
    end
    return -1;
  endfunction

  function automatic bit all_idle();
    for (int q = 0; q < 2*N; q++) if (fq[q].size() != 0) return 1'b0;
    return (obq[0].size() == 0) && (obq[1].size() == 0);
  endfunction

  function automatic logic [W+1:0] log_at(input int u, input int i);
    if (i < plog[u].size()) return plog[u][i];
    return '1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    for (int u = 0; u < 2; u++) begin
      check_eq($sformatf("%s_count%0d", tag, u), 64'(cnt_o[u]), 64'd0);
      check_eq($sformatf("%s_empty%0d", tag, u), 64'(emp_o[u]), 64'd1);
      check_eq($sformatf("%s_rdata%0d", tag, u), 64'(rd_o[u]), 64'd0);
      check_eq($sformatf("%s_src%0d", tag, u), 64'(src_o[u]), 64'd0);
      check_eq($sformatf("%s_edq%0d", tag, u), 64'(edq_o[u]), 64'd0);
    end
  endtask

  // One clock: compare against the model before the edge, then advance the model.
  task automatic cyc();
    int g [2];
    bit pv [2];
    int nxt;
    logic [W+1:0] head;
    drive_egress();
    @(negedge clk_i);
    for (int u = 0; u < 2; u++) begin
      head  = (obq[u].size() > 0) ? obq[u][0] : '0;
      g[u]  = model_grant(u);
      pv[u] = dequeue_i && (obq[u].size() > 0);
      check_eq($sformatf("count%0d", u), 64'(cnt_o[u]), 64'(obq[u].size()));
      check_eq($sformatf("empty%0d", u), 64'(emp_o[u]), 64'(obq[u].size() == 0));
      check_eq($sformatf("rdata%0d", u), 64'(rd_o[u]), 64'(head[W-1:0]));
      check_eq($sformatf("src_id%0d", u), 64'(src_o[u]), 64'(head[W+1:W]));
      check_eq($sformatf("egress_dequeue%0d", u), 64'(edq_o[u]),
               (g[u] >= 0) ? 64'(1 << g[u]) : 64'd0);
      if (pv[u]) plog[u].push_back({src_o[u], rd_o[u]});
    end
    @(posedge clk_i);
    #1;
    for (int u = 0; u < 2; u++) begin
      if (pv[u]) void'(obq[u].pop_front());
      if (g[u] >= 0) obq[u].push_back({2'(g[u]), fq[u*N+g[u]].pop_front()});
      if (!rr_mode_i) begin
        mptr[u]  = int'(sel_i);
        mbcnt[u] = 0;
      end else if (g[u] >= 0) begin
        nxt = (g[u] == mptr[u]) ? mbcnt[u] + 1 : 1;
        if (nxt == bl[u]) begin
          mptr[u]  = (g[u] + 1) % N;
          mbcnt[u] = 0;
        end else begin
          mptr[u]  = g[u];
          mbcnt[u] = nxt;
        end
      end
    end
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    rr_mode_i = 1'b1;
    dequeue_i = 1'b1;
    while (budget > 0 && !all_idle()) begin
      cyc();
      budget--;
    end
    check_eq("drain_done", 64'(all_idle()), 64'd1);
  endtask

  task automatic clear_logs();
    plog[0].delete();
    plog[1].delete();
  endtask

  initial begin
    rr_mode_i = 1'b1;
    dequeue_i = 1'b1;
    for (int u = 0; u < 2; u++) begin
      eemp[u] = '0;
      mptr[u] = 0;
      mbcnt[u] = 0;
    end
    for (int k = 0; k < N; k++) begin
      erd0[k] = W'(k + 1);
      erd1[k] = W'(k + 1);
    end
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rst_ni = 1'b1;

    repeat (10) cyc();

    for (int k = 0; k < N; k++) load(k, 6, W'(32'h100 * k));
    rr_mode_i = 1'b0;
    sel_i = 2'd2;
    dequeue_i = 1'b0;
    repeat (4) cyc();
    check_eq("fixed_full_count", 64'(cnt_o[0]), 64'd2);
    check_eq("fixed_full_no_pop", 64'(edq_o[0]), 64'd0);
    clear_logs();
    dequeue_i = 1'b1;
    repeat (6) cyc();
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("fixed_word%0d", i), 64'(log_at(0, i)), 64'({2'd2, W'(32'h200 + i)}));
    drain();

    rr_mode_i = 1'b0;
    sel_i = 2'd0;
    cyc();
    for (int k = 0; k < N; k++) load(k, 5, W'(32'h100 * k));
    clear_logs();
    rr_mode_i = 1'b1;
    dequeue_i = 1'b1;
    repeat (20) cyc();
    for (int i = 0; i < 17; i++)
      check_eq($sformatf("rr_burst4_%0d", i), 64'(log_at(0, i)),
               64'({2'((i / 4) % 4), W'(32'h100 * ((i / 4) % 4) + (i / 16) * 4 + i % 4)}));
    drain();

    rr_mode_i = 1'b0;
    sel_i = 2'd0;
    cyc();
    load(0, 3, W'(32'h10));
    load(2, 1, W'(32'h20));
    clear_logs();
    rr_mode_i = 1'b1;
    dequeue_i = 1'b1;
    repeat (8) cyc();
    check_eq("skip_bl2_len", 64'(plog[1].size()), 64'd4);
    check_eq("skip_bl2_0", 64'(log_at(1, 0)), 64'({2'd0, W'(32'h10)}));
    check_eq("skip_bl2_1", 64'(log_at(1, 1)), 64'({2'd0, W'(32'h11)}));
    check_eq("skip_bl2_2", 64'(log_at(1, 2)), 64'({2'd2, W'(32'h20)}));
    check_eq("skip_bl2_3", 64'(log_at(1, 3)), 64'({2'd0, W'(32'h12)}));
    check_eq("skip_bl4_3", 64'(log_at(0, 3)), 64'({2'd2, W'(32'h20)}));
    drain();

    load(3, 6, W'(32'h300));
    rr_mode_i = 1'b0;
    sel_i = 2'd3;
    dequeue_i = 1'b0;
    repeat (3) cyc();
    check_eq("full_count", 64'(cnt_o[0]), 64'd2);
    clear_logs();
    dequeue_i = 1'b1;
    repeat (4) cyc();
    check_eq("full_pushpop_count", 64'(cnt_o[0]), 64'd2);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("full_order%0d", i), 64'(log_at(0, i)), 64'({2'd3, W'(32'h300 + i)}));
    drain();

    for (int k = 0; k < N; k++) load(k, 6, W'(32'h100 * k + 32'h40));
    rr_mode_i = 1'b0;
    sel_i = 2'd1;
    dequeue_i = 1'b0;
    repeat (2) cyc();
    rr_mode_i = 1'b1;
    dequeue_i = 1'b1;
    drive_egress();
    #2;
    check_eq("midrst_active_deq", 64'(edq_o[0]), 64'(1 << model_grant(0)));
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk_i);
    #1;
    check_reset_outputs("midrst_hold");
    rst_ni = 1'b1;
    for (int u = 0; u < 2; u++) begin
      obq[u].delete();
      mptr[u] = 0;
      mbcnt[u] = 0;
    end
    clear_logs();
    repeat (3) cyc();
    check_eq("midrst_resume0", 64'(log_at(0, 0)), 64'({2'd0, W'(32'h40)}));
    check_eq("midrst_resume1", 64'(log_at(1, 0)), 64'({2'd0, W'(32'h40)}));
    drain();

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(15) == 0) rr_mode_i = ~rr_mode_i;
      sel_i = 2'($urandom_range(3));
      dequeue_i = ($urandom_range(3) != 0);
      for (int q = 0; q < 2*N; q++)
        if (fq[q].size() < 4 && $urandom_range(3) == 0)
          fq[q].push_back({4'($urandom()), $urandom()});
      cyc();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
